// File: rtl/robo_cmd_sched.sv
// robo_cmd_sched
//
// Sits between the robot controller FSM and the maze memory model. It takes
// the controller's level-held requests and turns them into paced, mutually
// exclusive one-cycle command pulses, each with a matching ack. It also
// enforces a move budget and detects a robot that keeps turning without
// advancing. Either condition parks the block in HALT until reset.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       allows new requests to be accepted (sampled only in IDLE)
//   req_avancar  move-forward request, held until ack
//   req_girar    rotate request, held until ack
//   req_remover  remove-barrier request, held until ack
//   avancar      one-cycle command pulse to the maze memory
//   girar        one-cycle command pulse to the maze memory
//   remover      one-cycle command pulse to the maze memory
//   ack          one-cycle pulse, coincident with the command pulse
//   busy         high while a command is being issued or cooling down
//   move_count   number of avancar commands issued
//   turn_run     current run of consecutive girar commands
//   stuck        sticky, set when turn_run reaches MAX_TURNS
//   halted       sticky, high in HALT
module robo_cmd_sched #(
    parameter int STEP_DIV  = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_MOVES = 1000,
    parameter int MAX_TURNS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             req_avancar,
    input  logic             req_girar,
    input  logic             req_remover,
    output logic             avancar,
    output logic             girar,
    output logic             remover,
    output logic             ack,
    output logic             busy,
    output logic [CNT_W-1:0] move_count,
    output logic [2:0]       turn_run,
    output logic             stuck,
    output logic             halted
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COOL, S_HALT} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_AV, CMD_GI, CMD_RE} cmd_t;

    state_t           state_reg, state_next;
    cmd_t             cmd_reg, cmd_next;
    logic [7:0]       cool_reg, cool_next;
    logic [CNT_W-1:0] move_reg, move_next;
    logic [2:0]       turn_reg, turn_next;
    logic             stuck_reg, stuck_next;

    logic av_reg, gi_reg, re_reg, ack_reg, busy_reg, halted_reg;

    // Next-state and counter logic
    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        cool_next  = cool_reg;
        move_next  = move_reg;
        turn_next  = turn_reg;
        stuck_next = stuck_reg;

        case (state_reg)
            S_IDLE: begin
                if (enable && (req_remover || req_girar || req_avancar)) begin
                    state_next = S_ISSUE;
                    // remover > girar > avancar; losers stay pending upstream
                    if (req_remover)     cmd_next = CMD_RE;
                    else if (req_girar)  cmd_next = CMD_GI;
                    else                 cmd_next = CMD_AV;
                end
            end
            S_ISSUE: begin
                case (cmd_reg)
                    CMD_AV: begin
                        move_next = move_reg + CNT_W'(1);
                        turn_next = 3'd0;
                    end
                    CMD_GI:  turn_next = turn_reg + 3'd1;
                    default: ;
                endcase
                // Halt decisions look at the post-update counter values
                if (move_next == CNT_W'(MAX_MOVES) || turn_next == 3'(MAX_TURNS)) begin
                    state_next = S_HALT;
                    if (turn_next == 3'(MAX_TURNS))
                        stuck_next = 1'b1;
                end else begin
                    state_next = S_COOL;
                    cool_next  = 8'(STEP_DIV - 1);
                end
            end
            S_COOL: begin
                if (cool_reg == 8'd0)
                    state_next = S_IDLE;
                else
                    cool_next = cool_reg - 8'd1;
            end
            default: ; // S_HALT is absorbing
        endcase
    end

    // State, counters and registered outputs. Outputs are derived from the
    // next state so that pulses line up with the ISSUE cycle without any
    // combinational path from the request inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cmd_reg    <= CMD_NONE;
            cool_reg   <= 8'd0;
            move_reg   <= '0;
            turn_reg   <= 3'd0;
            stuck_reg  <= 1'b0;
            av_reg     <= 1'b0;
            gi_reg     <= 1'b0;
            re_reg     <= 1'b0;
            ack_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cmd_reg    <= cmd_next;
            cool_reg   <= cool_next;
            move_reg   <= move_next;
            turn_reg   <= turn_next;
            stuck_reg  <= stuck_next;
            av_reg     <= (state_next == S_ISSUE) && (cmd_next == CMD_AV);
            gi_reg     <= (state_next == S_ISSUE) && (cmd_next == CMD_GI);
            re_reg     <= (state_next == S_ISSUE) && (cmd_next == CMD_RE);
            ack_reg    <= (state_next == S_ISSUE);
            busy_reg   <= (state_next == S_ISSUE) || (state_next == S_COOL);
            halted_reg <= (state_next == S_HALT);
        end
    end

    assign avancar    = av_reg;
    assign girar      = gi_reg;
    assign remover    = re_reg;
    assign ack        = ack_reg;
    assign busy       = busy_reg;
    assign move_count = move_reg;
    assign turn_run   = turn_reg;
    assign stuck      = stuck_reg;
    assign halted     = halted_reg;

endmodule
